// File: rtl/prod_acc_pkg.sv
// prod_acc_pkg: shared widths and FSM encoding for the product accumulator.
// The build macro ACC_SAT_EN selects a saturating accumulator in place of a
// wrapping one.
package prod_acc_pkg;

  localparam int PROD_W_DEF = 8;
  localparam int ACC_W_DEF  = 12;
  localparam int CNT_W_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/prod_acc_if.sv
// prod_acc_if: job control, product stream and result handshake of the
// product accumulator. master = job source / product producer / result
// consumer, slave = the accumulator.
interface prod_acc_if #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 12,
  parameter int CNT_W  = 4
);

  logic              start;
  logic [CNT_W-1:0]  len;
  logic              prod_valid;
  logic              prod_ready;
  logic [PROD_W-1:0] prod;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res;
  logic              ovf;
  logic              busy;

  modport master (
    output start, len, prod_valid, prod, res_ready,
    input  prod_ready, res_valid, res, ovf, busy
  );

  modport slave (
    input  start, len, prod_valid, prod, res_ready,
    output prod_ready, res_valid, res, ovf, busy
  );

endinterface

// File: rtl/prod_acc_add.sv
// prod_acc_add: ACC_W-bit adder of the running sum and a zero-extended
// product. The carry out feeds the overflow flag and the optional
// saturation mux in the parent.
module prod_acc_add #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 12
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [PROD_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] b_ext;
  logic [ACC_W:0] full;

  // one spare bit on top captures the carry out of ACC_W
  always_comb begin
    b_ext        = {{(ACC_W + 1 - PROD_W){1'b0}}, b};
    full         = {1'b0, a} + b_ext;
    sum          = full[ACC_W-1:0];
    carry        = full[ACC_W];
  end

endmodule

// File: rtl/prod_accumulator.sv
// prod_accumulator: sums a burst of len products into an ACC_W accumulator
// and returns the total over a valid/ready result handshake.
// Build option: define ACC_SAT_EN to saturate on overflow instead of wrapping.
module prod_accumulator
  import prod_acc_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  prod_acc_if.slave bus
);

  state_e            state, nxt;
  logic [ACC_W-1:0]  acc;
  logic              ovf_q;
  logic [CNT_W-1:0]  rem;
  logic              xfer;
  logic [ACC_W-1:0]  sum;
  logic              carry;

  prod_acc_add #(.PROD_W(PROD_W), .ACC_W(ACC_W)) u_add (
    .a     (acc),
    .b     (bus.prod),
    .sum   (sum),
    .carry (carry)
  );

  assign xfer = bus.prod_valid & (state == ACCUM);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // next state and handshake outputs; start is only looked at in IDLE
  always_comb begin
    nxt            = state;
    bus.prod_ready = 1'b0;
    bus.res_valid  = 1'b0;
    bus.busy       = (state != IDLE);
    bus.res        = acc;
    bus.ovf        = ovf_q;
    case (state)
      IDLE: begin
        if (bus.start) nxt = (bus.len != '0) ? ACCUM : HOLD;
      end
      ACCUM: begin
        bus.prod_ready = 1'b1;
        if (xfer && rem == CNT_W'(1)) nxt = HOLD;
      end
      HOLD: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // accumulator, sticky overflow and remaining-product counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      ovf_q <= 1'b0;
      rem   <= '0;
    end else if (state == IDLE && bus.start) begin
      acc   <= '0;
      ovf_q <= 1'b0;
      rem   <= bus.len;
    end else if (xfer) begin
      rem   <= rem - CNT_W'(1);
      ovf_q <= ovf_q | carry;
`ifdef ACC_SAT_EN
      // once all-ones, any further add carries again, so it stays pinned
      acc   <= carry ? '1 : sum;
`else
      acc   <= sum;
`endif
    end
  end

endmodule

// File: tb/tb_prod_accumulator.sv
// tb_prod_accumulator: directed vectors with hand-computed sums for the
// product accumulator, built with ACC_W=10 so the overflow case is reachable.
module tb_prod_accumulator;

  localparam int PROD_W = 8;
  localparam int ACC_W  = 10;
  localparam int CNT_W  = 4;

  logic clk;
  logic rst_n;
  int   errs;
  int   checks;

  prod_acc_if #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  prod_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one cycle; outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.start      = 1'b0;
    bus.len        = '0;
    bus.prod_valid = 1'b0;
    bus.prod       = '0;
    bus.res_ready  = 1'b0;
  endtask

  logic [31:0] ovf_exp_res;

  initial begin
    errs   = 0;
    checks = 0;
    idle_in();
    rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst_rv",    32'(bus.res_valid), 0);
    chk("rst_pr",    32'(bus.prod_ready), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_res",  32'(bus.res), 0);
    chk("idle_ovf",  32'(bus.ovf), 0);
    chk("idle_busy", 32'(bus.busy), 0);

    // 1. basic job: 0x0F + 0xE1 + 0x01 = 0xF1
    bus.start = 1'b1; bus.len = 4'd3;
    tick();
    bus.start = 1'b0; bus.len = 4'd9;
    chk("t1_pr", 32'(bus.prod_ready), 1);
    bus.prod_valid = 1'b1; bus.prod = 8'h0F; tick();
    bus.prod = 8'hE1; tick();
    bus.prod = 8'h01;
    chk("t1_rv_early", 32'(bus.res_valid), 0);
    tick();
    bus.prod_valid = 1'b0;
    chk("t1_rv",  32'(bus.res_valid), 1);
    chk("t1_res", 32'(bus.res), 32'h0F1);
    chk("t1_ovf", 32'(bus.ovf), 0);
    chk("t1_pr_hold", 32'(bus.prod_ready), 0);
    bus.res_ready = 1'b1; tick();
    bus.res_ready = 1'b0;
    chk("t1_done", 32'(bus.busy), 0);

    // 2. empty job
    bus.start = 1'b1; bus.len = 4'd0; tick();
    bus.start = 1'b0;
    chk("t2_rv",  32'(bus.res_valid), 1);
    chk("t2_res", 32'(bus.res), 0);
    chk("t2_ovf", 32'(bus.ovf), 0);
    chk("t2_pr",  32'(bus.prod_ready), 0);
    bus.res_ready = 1'b1; tick();
    bus.res_ready = 1'b0;
    chk("t2_done", 32'(bus.busy), 0);

    // 3. gaps: valid 1,0,1,0,1 with 0x10,(0x55),0x20,(0x66),0x30 -> 0x60
    bus.start = 1'b1; bus.len = 4'd3; tick();
    bus.start = 1'b0;
    bus.prod_valid = 1'b1; bus.prod = 8'h10; tick();
    bus.prod_valid = 1'b0; bus.prod = 8'h55; tick();
    bus.prod_valid = 1'b1; bus.prod = 8'h20; tick();
    bus.prod_valid = 1'b0; bus.prod = 8'h66; tick();
    chk("t3_rv_early", 32'(bus.res_valid), 0);
    bus.prod_valid = 1'b1; bus.prod = 8'h30; tick();
    chk("t3_rv",  32'(bus.res_valid), 1);
    chk("t3_res", 32'(bus.res), 32'h060);
    // backpressure with start and products offered: nothing moves
    bus.start = 1'b1; bus.len = 4'd7; bus.prod = 8'h77;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_res", 32'(bus.res), 32'h060);
      chk("t3_hold_rv",  32'(bus.res_valid), 1);
      chk("t3_hold_pr",  32'(bus.prod_ready), 0);
    end
    bus.start = 1'b0; bus.prod_valid = 1'b0;
    bus.res_ready = 1'b1; tick();
    bus.res_ready = 1'b0;
    chk("t3_done", 32'(bus.busy), 0);

    // 4. overflow: 5 x 0xFF = 1275 -> 0x0FB wrapped in 10 bits
`ifdef ACC_SAT_EN
    ovf_exp_res = 32'h3FF;
`else
    ovf_exp_res = 32'h0FB;
`endif
    bus.start = 1'b1; bus.len = 4'd5; tick();
    bus.start = 1'b0;
    bus.prod_valid = 1'b1; bus.prod = 8'hFF;
    repeat (5) tick();
    bus.prod_valid = 1'b0;
    chk("t4_rv",  32'(bus.res_valid), 1);
    chk("t4_res", 32'(bus.res), ovf_exp_res);
    chk("t4_ovf", 32'(bus.ovf), 1);

    // 6. start during the result handshake is ignored; next cycle starts anew
    bus.res_ready = 1'b1; bus.start = 1'b1; bus.len = 4'd2; tick();
    bus.res_ready = 1'b0;
    chk("t6_idle", 32'(bus.busy), 0);
    chk("t6_rv",   32'(bus.res_valid), 0);
    tick();
    bus.start = 1'b0;
    chk("t6_busy", 32'(bus.busy), 1);
    chk("t6_clr",  32'(bus.res), 0);
    chk("t6_ovfclr", 32'(bus.ovf), 0);
    bus.prod_valid = 1'b1; bus.prod = 8'h03; tick();
    bus.prod = 8'h04; tick();
    bus.prod_valid = 1'b0;
    chk("t6_res", 32'(bus.res), 32'h007);
    chk("t6_ovf", 32'(bus.ovf), 0);
    bus.res_ready = 1'b1; tick();
    bus.res_ready = 1'b0;

    // 5. reset after 2 of 4 transfers
    bus.start = 1'b1; bus.len = 4'd4; tick();
    bus.start = 1'b0;
    bus.prod_valid = 1'b1; bus.prod = 8'h11;
    repeat (2) tick();
    chk("t5_part", 32'(bus.res), 32'h022);
    rst_n = 1'b0;
    #1;
    chk("t5_busy", 32'(bus.busy), 0);
    chk("t5_pr",   32'(bus.prod_ready), 0);
    chk("t5_rv",   32'(bus.res_valid), 0);
    chk("t5_res",  32'(bus.res), 0);
    idle_in();
    tick();
    rst_n = 1'b1;
    tick();
    bus.start = 1'b1; bus.len = 4'd1; tick();
    bus.start = 1'b0;
    bus.prod_valid = 1'b1; bus.prod = 8'h22; tick();
    bus.prod_valid = 1'b0;
    chk("t5_rv2",  32'(bus.res_valid), 1);
    chk("t5_res2", 32'(bus.res), 32'h022);
    chk("t5_ovf2", 32'(bus.ovf), 0);
    bus.res_ready = 1'b1; tick();
    bus.res_ready = 1'b0;
    chk("t5_done", 32'(bus.busy), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
